// File: rtl/audio_mix_sd_dac.sv
// rtl/audio_mix_sd_dac.sv - stereo multi-source mixer with cross-mix, mute, clip flags and sigma-delta DACs
module audio_mix_sd_dac #(
    parameter int IN_BITS = 16,
    parameter int NUM_IN  = 1
) (
    input  logic                      clk_sys,
    input  logic                      reset,
    input  logic                      ce_sample,
    input  logic [NUM_IN*IN_BITS-1:0] in_l,
    input  logic [NUM_IN*IN_BITS-1:0] in_r,
    input  logic [1:0]                mix_mode,
    input  logic                      mute,
    input  logic                      clip_clr,
    output logic                      sample_done,
    output logic                      clip_l,
    output logic                      clip_r,
    output logic                      dac_l,
    output logic                      dac_r
);

    // Sum width grows by log2 of the source count so the raw sum never wraps.
    localparam int S = IN_BITS + $clog2(NUM_IN);
    localparam int W = IN_BITS + 1;

    localparam logic signed [S-1:0]       SUM_MAX = S'((2 ** (IN_BITS - 1)) - 1);
    localparam logic signed [S-1:0]       SUM_MIN = S'(-(2 ** (IN_BITS - 1)));
    localparam logic signed [IN_BITS-1:0] SAT_MAX = {1'b0, {(IN_BITS - 1){1'b1}}};
    localparam logic signed [IN_BITS-1:0] SAT_MIN = {1'b1, {(IN_BITS - 1){1'b0}}};
    localparam logic [IN_BITS-1:0]        MID     = {1'b1, {(IN_BITS - 1){1'b0}}};

    logic signed [S-1:0]       sum_l_c, sum_r_c;
    logic signed [S-1:0]       sum_l_q, sum_r_q;
    logic                      v1, v2;
    logic                      ovf_l, ovf_r;
    logic signed [IN_BITS-1:0] sat_l, sat_r;
    logic signed [W-1:0]       wl, wr, diff, mix_m, mix_l, mix_r;
    logic [IN_BITS-1:0]        x_l, x_r;
    logic [IN_BITS-1:0]        tgt_l, tgt_r;
    logic [IN_BITS:0]          acc_l, acc_r;

    // Sign-extend every source to the sum width and add them per side.
    always_comb begin
        sum_l_c = '0;
        sum_r_c = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            sum_l_c = sum_l_c + S'(signed'(in_l[i*IN_BITS +: IN_BITS]));
            sum_r_c = sum_r_c + S'(signed'(in_r[i*IN_BITS +: IN_BITS]));
        end
    end

    // S1: capture raw sums on the sample strobe.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            sum_l_q <= '0;
            sum_r_q <= '0;
            v1      <= 1'b0;
        end else begin
            v1 <= ce_sample;
            if (ce_sample) begin
                sum_l_q <= sum_l_c;
                sum_r_q <= sum_r_c;
            end
        end
    end

    // Saturate to the DAC word range, then cross-mix one bit wider; L-m and R+m stay in range.
    always_comb begin
        ovf_l = (sum_l_q > SUM_MAX) || (sum_l_q < SUM_MIN);
        ovf_r = (sum_r_q > SUM_MAX) || (sum_r_q < SUM_MIN);
        sat_l = (sum_l_q > SUM_MAX) ? SAT_MAX : (sum_l_q < SUM_MIN) ? SAT_MIN : sum_l_q[IN_BITS-1:0];
        sat_r = (sum_r_q > SUM_MAX) ? SAT_MAX : (sum_r_q < SUM_MIN) ? SAT_MIN : sum_r_q[IN_BITS-1:0];
        wl    = W'(sat_l);
        wr    = W'(sat_r);
        diff  = wl - wr;
        case (mix_mode)
            2'd1:    mix_m = diff >>> 3;
            2'd2:    mix_m = diff >>> 2;
            2'd3:    mix_m = diff >>> 1;
            default: mix_m = '0;
        endcase
        mix_l = wl - mix_m;
        mix_r = wr + mix_m;
    end

    // S2: register the mixed words.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            x_l <= '0;
            x_r <= '0;
            v2  <= 1'b0;
        end else begin
            v2 <= v1;
            if (v1) begin
                x_l <= mix_l[IN_BITS-1:0];
                x_r <= mix_r[IN_BITS-1:0];
            end
        end
    end

    // Sticky clip flags; a new saturation beats a simultaneous clear.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            clip_l <= 1'b0;
            clip_r <= 1'b0;
        end else begin
            if (v1 && ovf_l)   clip_l <= 1'b1;
            else if (clip_clr) clip_l <= 1'b0;
            if (v1 && ovf_r)   clip_r <= 1'b1;
            else if (clip_clr) clip_r <= 1'b0;
        end
    end

    // S3: convert to offset binary (or midscale when muted) and load the DAC targets.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            tgt_l       <= MID;
            tgt_r       <= MID;
            sample_done <= 1'b0;
        end else begin
            sample_done <= v2;
            if (v2) begin
                tgt_l <= mute ? MID : {~x_l[IN_BITS-1], x_l[IN_BITS-2:0]};
                tgt_r <= mute ? MID : {~x_r[IN_BITS-1], x_r[IN_BITS-2:0]};
            end
        end
    end

    // First-order sigma-delta: the carry out of the accumulator is the output bit.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            acc_l <= '0;
            acc_r <= '0;
        end else begin
            acc_l <= {1'b0, acc_l[IN_BITS-1:0]} + {1'b0, tgt_l};
            acc_r <= {1'b0, acc_r[IN_BITS-1:0]} + {1'b0, tgt_r};
        end
    end

    assign dac_l = acc_l[IN_BITS];
    assign dac_r = acc_r[IN_BITS];

endmodule

// File: tb/tb_audio_mix_sd_dac.sv
// tb/tb_audio_mix_sd_dac.sv - scoreboard bench for audio_mix_sd_dac
module tb_audio_mix_sd_dac;

    localparam int IN_BITS = 8;
    localparam int NUM_IN  = 2;

    logic        clk_sys   = 1'b0;
    logic        reset     = 1'b1;
    logic        ce_sample = 1'b0;
    logic [15:0] in_l      = '0;
    logic [15:0] in_r      = '0;
    logic [1:0]  mix_mode  = '0;
    logic        mute      = 1'b0;
    logic        clip_clr  = 1'b0;
    logic        sample_done, clip_l, clip_r, dac_l, dac_r;

    int          checks   = 0;
    int          failures = 0;
    int          done_cnt = 0;
    int          base_cnt;
    int          ones_l, ones_r;
    logic [15:0] sb[$];
    logic [15:0] mon_exp;

    audio_mix_sd_dac #(.IN_BITS(IN_BITS), .NUM_IN(NUM_IN)) dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .ce_sample  (ce_sample),
        .in_l       (in_l),
        .in_r       (in_r),
        .mix_mode   (mix_mode),
        .mute       (mute),
        .clip_clr   (clip_clr),
        .sample_done(sample_done),
        .clip_l     (clip_l),
        .clip_r     (clip_r),
        .dac_l      (dac_l),
        .dac_r      (dac_r)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] model(input int l0, input int l1, input int r0, input int r1,
                                          input int mode, input bit mu);
        int l, r, d, m;
        l = l0 + l1;
        r = r0 + r1;
        if (l > 127)  l = 127;
        if (l < -128) l = -128;
        if (r > 127)  r = 127;
        if (r < -128) r = -128;
        d = l - r;
        case (mode)
            1:       m = d >>> 3;
            2:       m = d >>> 2;
            3:       m = d >>> 1;
            default: m = 0;
        endcase
        if (mu) return 16'h8080;
        l = l - m;
        r = r + m;
        return {8'(l + 128), 8'(r + 128)};
    endfunction

    // Pop the oldest expected pair whenever the DUT reports a load.
    always @(negedge clk_sys) begin
        if (!reset && sample_done) begin
            done_cnt++;
            chk("sb_avail", sb.size() > 0, 1);
            if (sb.size() > 0) begin
                mon_exp = sb.pop_front();
                chk("tgt_l", dut.tgt_l, mon_exp[15:8]);
                chk("tgt_r", dut.tgt_r, mon_exp[7:0]);
            end
        end
    end

    task automatic send_one(input int l0, input int l1, input int r0, input int r1,
                            input logic [1:0] mode, input logic mu, input logic cc,
                            input logic [15:0] exp);
        @(posedge clk_sys); #1;
        in_l      = {8'(l1), 8'(l0)};
        in_r      = {8'(r1), 8'(r0)};
        mix_mode  = mode;
        mute      = mu;
        ce_sample = 1'b1;
        sb.push_back(exp);
        @(posedge clk_sys); #1;
        ce_sample = 1'b0;
        clip_clr  = cc;
        @(posedge clk_sys); #1;
        clip_clr  = 1'b0;
        chk("sd_early", sample_done, 0);
        @(posedge clk_sys); #1;
        chk("sd_latency", sample_done, 1);
        @(posedge clk_sys); #1;
        chk("sd_pulse", sample_done, 0);
    endtask

    task automatic count_ones(output int nl, output int nr);
        nl = 0;
        nr = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk_sys);
            nl += int'(dac_l);
            nr += int'(dac_r);
        end
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk_sys);
        #1;
        chk("rst_dac_l", dac_l, 0);
        chk("rst_dac_r", dac_r, 0);
        chk("rst_done", sample_done, 0);
        chk("rst_clip_l", clip_l, 0);
        chk("rst_tgt_l", dut.tgt_l, 8'h80);
        @(negedge clk_sys);
        reset = 1'b0;

        // 1: idle midscale output
        count_ones(ones_l, ones_r);
        chk("t1_ones_l", ones_l, 128);
        chk("t1_ones_r", ones_r, 128);
        chk("t1_no_done", done_cnt, 0);

        // 2: saturating left sum, mode 0
        send_one(8'h70, 8'h70, 0, 0, 2'd0, 1'b0, 1'b0, 16'hFF80);
        chk("t2_clip_l", clip_l, 1);
        chk("t2_clip_r", clip_r, 0);

        // 3: 25% mix and resulting density
        send_one(64, 0, 0, 0, 2'd1, 1'b0, 1'b0, 16'hB888);
        count_ones(ones_l, ones_r);
        chk("t3_ones_l", ones_l, 184);
        chk("t3_ones_r", ones_r, 136);

        // 4: mono and 50% mix, plus a saturated extreme under mono
        send_one(64, 0, -64, 0, 2'd3, 1'b0, 1'b0, 16'h8080);
        send_one(1, 0, 0, 0, 2'd2, 1'b0, 1'b0, 16'h8180);
        send_one(100, 100, -100, -100, 2'd3, 1'b0, 1'b0, 16'h807F);

        // 5: mute keeps clip detection; set beats clear; clear alone works
        send_one(127, 127, -128, -128, 2'd0, 1'b1, 1'b0, model(127, 127, -128, -128, 0, 1'b1));
        chk("t5_clip_l_mute", clip_l, 1);
        chk("t5_clip_r_mute", clip_r, 1);
        send_one(127, 127, 0, 0, 2'd0, 1'b0, 1'b1, model(127, 127, 0, 0, 0, 1'b0));
        chk("t5_set_wins_l", clip_l, 1);
        chk("t5_clr_r", clip_r, 0);
        @(posedge clk_sys); #1;
        clip_clr = 1'b1;
        @(posedge clk_sys); #1;
        clip_clr = 1'b0;
        chk("t5_clr_l", clip_l, 0);

        // 6: back-to-back samples, reset after the second load
        base_cnt = done_cnt;
        mix_mode = 2'd2;
        mute     = 1'b0;
        @(posedge clk_sys); #1;
        in_l = {8'(5), 8'(10)};   in_r = {8'(0), 8'(-3)};   ce_sample = 1'b1;
        sb.push_back(model(10, 5, -3, 0, 2, 1'b0));
        @(posedge clk_sys); #1;
        in_l = {8'(7), 8'(-20)};  in_r = {8'(1), 8'(40)};
        sb.push_back(model(-20, 7, 40, 1, 2, 1'b0));
        @(posedge clk_sys); #1;
        in_l = {8'(60), 8'(60)};  in_r = {8'(-70), 8'(-70)};
        sb.push_back(model(60, 60, -70, -70, 2, 1'b0));
        @(posedge clk_sys); #1;
        in_l = {8'(2), 8'(1)};    in_r = {8'(4), 8'(3)};
        sb.push_back(model(1, 2, 3, 4, 2, 1'b0));
        @(posedge clk_sys); #1;
        ce_sample = 1'b0;
        @(negedge clk_sys); #1;
        chk("t6_two_loaded", done_cnt - base_cnt, 2);
        reset = 1'b1;
        sb.delete();
        #1;
        chk("t6_rst_tgt_l", dut.tgt_l, 8'h80);
        chk("t6_rst_tgt_r", dut.tgt_r, 8'h80);
        chk("t6_rst_dac_l", dac_l, 0);
        chk("t6_rst_done", sample_done, 0);
        repeat (3) @(posedge clk_sys);
        @(negedge clk_sys);
        reset = 1'b0;
        repeat (10) @(posedge clk_sys);
        #1;
        chk("t6_no_late_load", done_cnt - base_cnt, 2);
        chk("t6_hold_tgt_l", dut.tgt_l, 8'h80);
        count_ones(ones_l, ones_r);
        chk("t6_ones_l", ones_l, 128);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
